// File: rtl/mips_pipe3_fwd.sv
// mips_pipe3_fwd: 3-stage 16-bit MIPS subset core (IF / ID / EX+WB)
// with EX->ID forwarding, halt freeze and illegal-opcode flagging.
module mips_pipe3_fwd #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  output logic [PC_W-2:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic [PC_W-1:0]   PC,
  output logic [15:0]       IFID_IR,
  output logic [15:0]       IDEX_IR,
  output logic [DATA_W-1:0] WD,
  output logic [1:0]        WR,
  output logic              reg_we,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_e;

  logic [DATA_W-1:0] rf [4];

  logic [3:0]        op;
  logic [1:0]        rs;
  logic [1:0]        rt;
  logic [1:0]        rd;
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              fwd_rs;
  logic              fwd_rt;

  alu_e              d_alu;
  logic              d_imm;
  logic [1:0]        d_wr;
  logic              d_we;
  logic              d_ill;
  logic              d_halt;

  alu_e              ex_alu;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic              ex_we;

  assign imem_addr = PC[PC_W-1:1];

  assign op   = IFID_IR[15:12];
  assign rs   = IFID_IR[11:10];
  assign rt   = IFID_IR[9:8];
  assign rd   = IFID_IR[7:6];
  assign sext = {{(DATA_W-8){IFID_IR[7]}}, IFID_IR[7:0]};

  assign reg_we = ex_we && (WR != 2'd0);

  // Only a real write-back may be forwarded; reg_we already excludes r0.
  assign fwd_rs = FWD_EN && reg_we && (WR == rs);
  assign fwd_rt = FWD_EN && reg_we && (WR == rt);

  // Operand read: forwarded EX result, else register file (r0 is zero)
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (fwd_rs)
      rs_val = WD;
    else if (rs != 2'd0)
      rs_val = rf[rs];
    if (fwd_rt)
      rt_val = WD;
    else if (rt != 2'd0)
      rt_val = rf[rt];
  end

  // Instruction decode: unknown opcodes become nops flagged illegal
  always_comb begin
    d_alu  = ALU_ADD;
    d_imm  = 1'b0;
    d_wr   = rd;
    d_we   = 1'b0;
    d_ill  = 1'b0;
    d_halt = 1'b0;
    unique case (op)
      4'h0: d_we = 1'b1;
      4'h1: begin
        d_alu = ALU_SUB;
        d_we  = 1'b1;
      end
      4'h2: begin
        d_alu = ALU_AND;
        d_we  = 1'b1;
      end
      4'h3: begin
        d_alu = ALU_OR;
        d_we  = 1'b1;
      end
      4'h4: begin
        d_imm = 1'b1;
        d_wr  = rt;
        d_we  = 1'b1;
      end
      4'h7: begin
        d_alu = ALU_SLT;
        d_we  = 1'b1;
      end
      4'hF: d_halt = 1'b1;
      default: d_ill = 1'b1;
    endcase
  end

  // EX ALU: result is both the write-back and the forwarded value
  always_comb begin
    WD = '0;
    unique case (ex_alu)
      ALU_ADD: WD = ex_a + ex_b;
      ALU_SUB: WD = ex_a - ex_b;
      ALU_AND: WD = ex_a & ex_b;
      ALU_OR:  WD = ex_a | ex_b;
      ALU_SLT: WD = {{(DATA_W-1){1'b0}},
                     ($signed(ex_a) < $signed(ex_b))};
      default: WD = '0;
    endcase
  end

  // Fetch: advance PC, or freeze it and squash the fetch on halt
  always_ff @(posedge clock) begin
    if (reset) begin
      PC      <= '0;
      IFID_IR <= '0;
      halted  <= 1'b0;
    end else if (!halted) begin
      if (d_halt) begin
        IFID_IR <= '0;
        halted  <= 1'b1;
      end else begin
        PC      <= PC + PC_W'(2);
        IFID_IR <= imem_data;
      end
    end
  end

  // ID/EX register: halt and the halted state inject nops
  always_ff @(posedge clock) begin
    if (reset || halted || d_halt) begin
      IDEX_IR <= '0;
      ex_alu  <= ALU_ADD;
      ex_a    <= '0;
      ex_b    <= '0;
      WR      <= '0;
      ex_we   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      IDEX_IR <= IFID_IR;
      ex_alu  <= d_alu;
      ex_a    <= rs_val;
      ex_b    <= d_imm ? sext : rt_val;
      WR      <= d_wr;
      ex_we   <= d_we;
      illegal <= d_ill;
    end
  end

  // Register file write-back; reset discards the in-flight write
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++)
        rf[i] <= '0;
    end else if (reg_we) begin
      rf[WR] <= WD;
    end
  end

endmodule

// File: tb/tb_mips_pipe3_fwd.sv
// tb_mips_pipe3_fwd: scoreboard bench running the same programs on a
// forwarding core and a non-forwarding core against an ISA-level model.
module tb_mips_pipe3_fwd;

  typedef struct packed {
    logic        ill;
    logic [1:0]  wr;
    logic [15:0] wd;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [15:0] mem [64];
  logic [15:0] prog [$];
  ev_t qf [$];
  ev_t qn [$];
  int compared = 0;
  int mismatched = 0;

  logic [14:0] addr_f, addr_n;
  logic [15:0] data_f, data_n;
  logic [15:0] pc_f, pc_n;
  logic [15:0] ifid_f, ifid_n, idex_f, idex_n;
  logic [15:0] wd_f, wd_n;
  logic [1:0]  wr_f, wr_n;
  logic        we_f, we_n, halt_f, halt_n, ill_f, ill_n;

  assign data_f = mem[addr_f[5:0]];
  assign data_n = mem[addr_n[5:0]];

  mips_pipe3_fwd #(.DATA_W(16), .PC_W(16), .FWD_EN(1'b1)) dut_f (
    .clock(clock), .reset(reset),
    .imem_addr(addr_f), .imem_data(data_f),
    .PC(pc_f), .IFID_IR(ifid_f), .IDEX_IR(idex_f),
    .WD(wd_f), .WR(wr_f), .reg_we(we_f),
    .halted(halt_f), .illegal(ill_f)
  );

  mips_pipe3_fwd #(.DATA_W(16), .PC_W(16), .FWD_EN(1'b0)) dut_n (
    .clock(clock), .reset(reset),
    .imem_addr(addr_n), .imem_data(data_n),
    .PC(pc_n), .IFID_IR(ifid_n), .IDEX_IR(idex_n),
    .WD(wd_n), .WR(wr_n), .reg_we(we_n),
    .halted(halt_n), .illegal(ill_n)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write-back or illegal pulse consumes one expected event
  always @(negedge clock) begin
    ev_t e;
    if (we_f === 1'b1 || ill_f === 1'b1) begin
      if (qf.size() == 0) begin
        chk("fwd unexpected output", {we_f, ill_f}, 0);
      end else begin
        e = qf.pop_front();
        chk("fwd illegal", ill_f, e.ill);
        chk("fwd reg_we", we_f, !e.ill);
        if (!e.ill) begin
          chk("fwd WR", wr_f, e.wr);
          chk("fwd WD", wd_f, e.wd);
        end
      end
    end
    if (we_n === 1'b1 || ill_n === 1'b1) begin
      if (qn.size() == 0) begin
        chk("nofwd unexpected output", {we_n, ill_n}, 0);
      end else begin
        e = qn.pop_front();
        chk("nofwd illegal", ill_n, e.ill);
        chk("nofwd reg_we", we_n, !e.ill);
        if (!e.ill) begin
          chk("nofwd WR", wr_n, e.wr);
          chk("nofwd WD", wd_n, e.wd);
        end
      end
    end
  end

  // ISA model: without forwarding, the previous instruction's result
  // becomes visible only one instruction later.
  task automatic model(input bit fwd, input int limit);
    logic [15:0] r [4];
    logic [15:0] a, b, res, ir, pv;
    logic [1:0]  dst, pw;
    bit          ok, pend;
    ev_t         e;
    for (int k = 0; k < 4; k++) r[k] = 16'h0;
    pend = 0;
    pw = 0;
    pv = 0;
    for (int i = 0; i < limit && i < 64; i++) begin
      ir = mem[i];
      if (ir[15:12] == 4'hF) break;
      a = r[ir[11:10]];
      b = r[ir[9:8]];
      if (pend) r[pw] = pv;
      pend = 0;
      ok = 1;
      dst = ir[7:6];
      res = 16'h0;
      case (ir[15:12])
        4'h0: res = a + b;
        4'h1: res = a - b;
        4'h2: res = a & b;
        4'h3: res = a | b;
        4'h7: res = ($signed(a) < $signed(b)) ? 16'h1 : 16'h0;
        4'h4: begin
          dst = ir[9:8];
          res = a + {{8{ir[7]}}, ir[7:0]};
        end
        default: ok = 0;
      endcase
      if (!ok) begin
        e = '{ill: 1'b1, wr: 2'd0, wd: 16'h0};
        if (fwd) qf.push_back(e); else qn.push_back(e);
      end else if (dst != 2'd0) begin
        e = '{ill: 1'b0, wr: dst, wd: res};
        if (fwd) qf.push_back(e); else qn.push_back(e);
        if (fwd) r[dst] = res;
        else begin
          pend = 1;
          pw = dst;
          pv = res;
        end
      end
    end
  endtask

  function automatic int find_halt();
    for (int i = 0; i < 64; i++)
      if (mem[i][15:12] == 4'hF) return i;
    return 63;
  endfunction

  task automatic load();
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
  endtask

  task automatic gen_random();
    logic [3:0] ops [6];
    logic [3:0] op;
    int len, sel;
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2;
    ops[3] = 4'h3; ops[4] = 4'h4; ops[5] = 4'h7;
    len = $urandom_range(3, 20);
    prog = {};
    for (int i = 0; i < len; i++) begin
      sel = $urandom_range(0, 15);
      if (sel < 12) begin
        op = ops[$urandom_range(0, 5)];
        prog.push_back({op, 12'($urandom)});
      end else if (sel < 14) begin
        op = 4'($urandom_range(5, 14));
        if (op == 4'h7) op = 4'h5;
        prog.push_back({op, 12'($urandom)});
      end else if (sel == 14) begin
        prog.push_back(16'h0000);
      end else begin
        prog.push_back({4'h4, 2'($urandom), 2'b00, 8'($urandom)});
      end
    end
    prog.push_back({4'hF, 12'($urandom)});
    load();
  endtask

  // Called at a negedge; holds reset across exactly one posedge
  task automatic reset_pulse();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst PC", pc_f, 0);
    chk("rst IFID_IR", ifid_f, 0);
    chk("rst IDEX_IR", idex_f, 0);
    chk("rst WD", wd_f, 0);
    chk("rst WR", wr_f, 0);
    chk("rst reg_we", we_f, 0);
    chk("rst halted", halt_f, 0);
    chk("rst illegal", ill_f, 0);
    chk("rst nofwd PC", pc_n, 0);
    chk("rst nofwd halted", halt_n, 0);
  endtask

  task automatic run_prog(input string tag);
    int h, cyc;
    h = find_halt();
    model(1'b1, 64);
    model(1'b0, 64);
    cyc = 0;
    while (!(halt_f === 1'b1 && halt_n === 1'b1) && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    repeat (3) @(negedge clock);
    chk({tag, " halted"}, halt_f, 1);
    chk({tag, " nofwd halted"}, halt_n, 1);
    chk({tag, " PC frozen"}, pc_f, 2 * (h + 1));
    chk({tag, " nofwd PC frozen"}, pc_n, 2 * (h + 1));
    chk({tag, " IFID squashed"}, ifid_f, 0);
    chk({tag, " IDEX bubble"}, idex_f, 0);
    chk({tag, " fwd pending"}, qf.size(), 0);
    chk({tag, " nofwd pending"}, qn.size(), 0);
    qf = {};
    qn = {};
  endtask

  initial begin
    prog = {16'h410F, 16'h4207, 16'h29C0, 16'h1780, 16'h3E80,
            16'h0BC0, 16'h7E40, 16'h7B40, 16'hF000};
    load();
    reset_pulse();
    run_prog("main");

    prog = {16'h410F, 16'h4207, 16'h0000, 16'h29C0, 16'hF000};
    load();
    @(negedge clock);
    reset_pulse();
    run_prog("nop gap");

    prog = {16'h41FF, 16'h0000, 16'h7480, 16'hF000};
    load();
    reset_pulse();
    run_prog("slt signed");

    prog = {16'h4005, 16'h0040, 16'hF000};
    load();
    reset_pulse();
    run_prog("r0 write");

    prog = {16'h410F, 16'h5ABC, 16'h0580, 16'hF000};
    load();
    reset_pulse();
    run_prog("illegal");

    prog = {16'h0C40, 16'h4207, 16'h4305, 16'hF000};
    load();
    reset_pulse();
    model(1'b1, 3);
    model(1'b0, 3);
    repeat (4) @(negedge clock);
    reset_pulse();
    chk("midrst fwd drained", qf.size(), 0);
    chk("midrst nofwd drained", qn.size(), 0);
    qf = {};
    qn = {};
    run_prog("midrst rerun");

    for (int t = 0; t < 25; t++) begin
      gen_random();
      reset_pulse();
      run_prog("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
